// File: rtl/pin_test_pkg.sv
// Shared definitions for the pin pattern checker and the pattern transmitter:
// default width, seed word, checker states and the circular rule-30 step.
package pin_test_pkg;

    localparam int WIDTH_DEF = 110;
    localparam int WIDTH_MAX = 512;

    localparam logic [WIDTH_MAX-1:0] SEED_WORD = WIDTH_MAX'(1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } chk_state_e;

    // Only the low 'width' bits take part; the ring wraps at width, not WIDTH_MAX.
    function automatic logic [WIDTH_MAX-1:0] next_word(input logic [WIDTH_MAX-1:0] x,
                                                       input int width);
        logic [WIDTH_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH_MAX; i++) begin
            if (i < width) begin
                r[i] = x[(i + 1) % width] ^ (x[i] | x[(i + width - 1) % width]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/word_settle.sv
// Two-flop pin synchronizer followed by a stability filter that reports each
// newly settled word exactly once.
module word_settle
    import pin_test_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STABLE = 4
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] s,
    output logic             settled,
    output logic [WIDTH-1:0] w
);

    localparam int CNT_W = $clog2(STABLE);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE - 2);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A word that reappears after a short glitch is not reported a second time.
    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        settled = (sync2_q == prev_q) && (cnt_q == CNT_FIRE) && (sync2_q != last_q);
        if (sync2_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        last_d = settled ? sync2_q : last_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s = sync2_q;
    assign w = sync2_q;

endmodule

// File: rtl/pin_pattern_checker.sv
// Locks onto a circular rule-30 word stream arriving on asynchronous pins and
// keeps step, error and per-pin mismatch statistics while locked.
module pin_pattern_checker
    import pin_test_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int STABLE   = 4,
    parameter int MISS_MAX = 3,
    parameter int ERR_W    = 16
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D_in,
    input  logic             clr,
    output logic             locked,
    output logic [31:0]      step_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic [WIDTH-1:0] err_mask,
    output logic             err_pulse
);

    localparam int MISS_W = $clog2(MISS_MAX + 1);

    logic [WIDTH-1:0] sync_word;
    logic [WIDTH-1:0] settle_w;
    logic             settled;
    logic [WIDTH-1:0] pred;
    logic             word_zero;

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [31:0]      step_cnt_q, step_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] err_mask_q, err_mask_d;
    logic             err_pulse_q, err_pulse_d;
    logic             locked_q, locked_d;

    word_settle #(
        .WIDTH  (WIDTH),
        .STABLE (STABLE)
    ) u_settle (
        .pclk    (pclk),
        .rst     (rst),
        .d_in    (D_in),
        .s       (sync_word),
        .settled (settled),
        .w       (settle_w)
    );

    always_comb begin
        pred      = WIDTH'(next_word(WIDTH_MAX'(ref_q), WIDTH));
        word_zero = (sync_word == '0);

        state_d     = state_q;
        ref_d       = ref_q;
        miss_d      = miss_q;
        step_cnt_d  = step_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_mask_d  = err_mask_q;
        err_pulse_d = 1'b0;

        if (settled) begin
            case (state_q)
                ST_SEARCH: begin
                    if (!word_zero) begin
                        ref_d   = settle_w;
                        state_d = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (word_zero) begin
                        state_d = ST_SEARCH;
                    end else begin
                        ref_d = settle_w;
                        if (settle_w == pred) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    ref_d = settle_w;
                    if (settle_w == pred) begin
                        step_cnt_d = step_cnt_q + 32'd1;
                        miss_d     = '0;
                    end else begin
                        err_mask_d  = err_mask_q | (settle_w ^ pred);
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (miss_q == MISS_W'(MISS_MAX - 1)) begin
                            miss_d  = '0;
                            state_d = ST_SEARCH;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        // Clear drops any statistics update from this cycle but leaves the pulse.
        if (clr) begin
            step_cnt_d = '0;
            err_cnt_d  = '0;
            err_mask_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            ref_q       <= '0;
            miss_q      <= '0;
            step_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_mask_q  <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            miss_q      <= miss_d;
            step_cnt_q  <= step_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_mask_q  <= err_mask_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign step_cnt  = step_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_mask  = err_mask_q;
    assign err_pulse = err_pulse_q;

endmodule
